// File: rtl/lenet_pkg.sv
// Shared LeNet pooling constants: window geometry and the packing order that
// this window buffer and the max comparator both rely on.
package lenet_pkg;
    localparam int BITWIDTH_DEF = 8;
    localparam int POOL_SIZE    = 2;
    localparam int WINDOW_LEN   = POOL_SIZE * POOL_SIZE;

    // Element slots inside a packed window word, slot 0 in the LSBs
    localparam int IDX_TL = 0;
    localparam int IDX_TR = 1;
    localparam int IDX_BL = 2;
    localparam int IDX_BR = 3;

    typedef enum logic {
        ST_TOP    = 1'b0,
        ST_BOTTOM = 1'b1
    } pool_state_e;
endpackage

// File: rtl/pool_window_buffer_if.sv
// Pixel-in / window-out handshake bundle of the pooling window buffer.
interface pool_window_buffer_if
    import lenet_pkg::*;
#(
    parameter int BITWIDTH = BITWIDTH_DEF
);
    logic                           inValid;
    logic                           inReady;
    logic [BITWIDTH-1:0]            inData;
    logic                           outValid;
    logic                           outReady;
    logic [WINDOW_LEN*BITWIDTH-1:0] outWindow;
    logic                           outLast;

    modport master (
        output inValid, inData, outReady,
        input  inReady, outValid, outWindow, outLast
    );

    modport slave (
        input  inValid, inData, outReady,
        output inReady, outValid, outWindow, outLast
    );
endinterface

// File: rtl/pool_line_buffer.sv
// One-row register-array line buffer: one synchronous write port, two
// combinational read ports.
module pool_line_buffer #(
    parameter int  BITWIDTH = 8,
    parameter int  DEPTH    = 24,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [BITWIDTH-1:0] wdata,
    input  logic [AW-1:0]       raddr_a,
    output logic [BITWIDTH-1:0] rdata_a,
    input  logic [AW-1:0]       raddr_b,
    output logic [BITWIDTH-1:0] rdata_b
);
    logic [BITWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/pool_window_buffer.sv
// Assembles non-overlapping 2x2 stride-2 pooling windows from a raster pixel
// stream; the even row is parked in a line buffer, the odd row completes it.
module pool_window_buffer
    import lenet_pkg::*;
#(
    parameter int BITWIDTH   = BITWIDTH_DEF,
    parameter int IMG_WIDTH  = 24,
    parameter int IMG_HEIGHT = 24
) (
    input  logic            clk,
    input  logic            rst,
    pool_window_buffer_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int WW = WINDOW_LEN * BITWIDTH;

    if (IMG_WIDTH % POOL_SIZE != 0) begin : g_chk_width
        $error("pool_window_buffer: IMG_WIDTH must be even");
    end
    if (IMG_HEIGHT % POOL_SIZE != 0) begin : g_chk_height
        $error("pool_window_buffer: IMG_HEIGHT must be even");
    end

    pool_state_e         state, state_nxt;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [BITWIDTH-1:0] col_reg;
    logic [BITWIDTH-1:0] lb_tl, lb_tr;
    logic                accept, col_last, row_last;
    logic                lb_we, bl_we, win_load;
    logic [WW-1:0]       win_nxt;

    assign bus.inReady = !bus.outValid || bus.outReady;
    assign accept      = bus.inValid && bus.inReady;
    assign col_last    = (col == CW'(IMG_WIDTH - 1));
    assign row_last    = (row == RW'(IMG_HEIGHT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_TOP;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept && col_last) state_nxt = (state == ST_TOP) ? ST_BOTTOM : ST_TOP;
    end

    always_comb begin
        lb_we    = 1'b0;
        bl_we    = 1'b0;
        win_load = 1'b0;
        if (accept) begin
            case (state)
                ST_TOP:    lb_we = 1'b1;
                ST_BOTTOM: begin
                    if (col[0]) win_load = 1'b1;
                    else        bl_we    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)        col_reg <= '0;
        else if (bl_we) col_reg <= bus.inData;
    end

    // Window pixels always sit at the even column and the odd column after it
    pool_line_buffer #(
        .BITWIDTH (BITWIDTH),
        .DEPTH    (IMG_WIDTH)
    ) u_line_buf (
        .clk     (clk),
        .we      (lb_we),
        .waddr   (col),
        .wdata   (bus.inData),
        .raddr_a (col & ~CW'(1)),
        .rdata_a (lb_tl),
        .raddr_b (col),
        .rdata_b (lb_tr)
    );

    always_comb begin
        win_nxt = '0;
        win_nxt[IDX_TL*BITWIDTH +: BITWIDTH] = lb_tl;
        win_nxt[IDX_TR*BITWIDTH +: BITWIDTH] = lb_tr;
        win_nxt[IDX_BL*BITWIDTH +: BITWIDTH] = col_reg;
        win_nxt[IDX_BR*BITWIDTH +: BITWIDTH] = bus.inData;
    end

    // Load wins over consume, so back-to-back windows keep outValid high
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.outValid  <= 1'b0;
            bus.outWindow <= '0;
            bus.outLast   <= 1'b0;
        end else if (win_load) begin
            bus.outValid  <= 1'b1;
            bus.outWindow <= win_nxt;
            bus.outLast   <= row_last && col_last;
        end else if (bus.outReady) begin
            bus.outValid  <= 1'b0;
        end
    end
endmodule
